adc_serial_rx_mc: RTL and testbench

//  Parametrised multi-channel receiver for SPI-style serial ADCs (ADC7476-class: leading zeros + data, MSB first).

---
 rtl/adc_serial_rx_mc.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_serial_rx_mc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_rx_mc.sv
// Multi-channel SPI-style serial ADC receiver (ADC7476-class frames: leading
// zeros then data, MSB first). One shared active-low CS, N_CH data lines
// sampled in parallel on SCLK rising edges, internal sample-rate timer,
// valid/ack handshake with sticky overrun.
// Optional feature: define ADC_RX_AVG_EN for a per-channel decimate-by-4
// boxcar average on data_out.
module adc_serial_rx_mc #(
    parameter int N_CH       = 2,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int SAMPLE_DIV = 32
) (
    input  logic                       SCLK,
    input  logic                       reset,
    input  logic                       rx_en,
    input  logic [N_CH-1:0]            ADCdata,
    input  logic                       data_ack,
    input  logic                       clear_ovr,
    output logic                       CS,
    output logic                       rx_done_tick,
    output logic                       data_valid,
    output logic [N_CH*DATA_BITS-1:0]  data_out,
    output logic [N_CH*FRAME_BITS-1:0] b_reg,
    output logic [N_CH-1:0]            frame_err,
    output logic                       overrun
);

    localparam int BIT_W  = $clog2(FRAME_BITS);
    localparam int RATE_W = $clog2(SAMPLE_DIV);
`ifdef ADC_RX_AVG_EN
    localparam int ACC_W  = DATA_BITS + 2;
`endif

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE, S_WAIT} state_t;

    state_t                               state_q, state_d;
    logic                                 cs_q, cs_d;
    logic [BIT_W-1:0]                     bit_cnt_q, bit_cnt_d;
    logic [RATE_W-1:0]                    rate_cnt_q, rate_cnt_d;
    // Only the first FRAME_BITS-1 bits are stored; the last bit is taken
    // straight from the pin on the completing edge.
    logic [N_CH-1:0][FRAME_BITS-2:0]      shreg_q, shreg_d;
    logic [N_CH-1:0][FRAME_BITS-1:0]      frame;
    logic [N_CH*FRAME_BITS-1:0]           b_reg_q, b_reg_d;
    logic [N_CH*DATA_BITS-1:0]            data_out_q, data_out_d;
    logic [N_CH-1:0]                      frame_err_q, frame_err_d;
    logic                                 tick_q, tick_d;
    logic                                 valid_q, valid_d;
    logic                                 ovr_q, ovr_d;
    logic                                 frame_done;
    logic                                 publish;
    logic [N_CH*DATA_BITS-1:0]            new_data;
`ifdef ADC_RX_AVG_EN
    logic [N_CH-1:0][ACC_W-1:0]           acc_q, acc_d;
    logic [1:0]                           fcnt_q, fcnt_d;
`endif

    // State and datapath registers; async active-low reset, CS idles high.
    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cs_q        <= 1'b1;
            bit_cnt_q   <= '0;
            rate_cnt_q  <= '0;
            shreg_q     <= '0;
            b_reg_q     <= '0;
            data_out_q  <= '0;
            frame_err_q <= '0;
            tick_q      <= 1'b0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
`ifdef ADC_RX_AVG_EN
            acc_q       <= '0;
            fcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            bit_cnt_q   <= bit_cnt_d;
            rate_cnt_q  <= rate_cnt_d;
            shreg_q     <= shreg_d;
            b_reg_q     <= b_reg_d;
            data_out_q  <= data_out_d;
            frame_err_q <= frame_err_d;
            tick_q      <= tick_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
`ifdef ADC_RX_AVG_EN
            acc_q       <= acc_d;
            fcnt_q      <= fcnt_d;
`endif
        end
    end

    // Next-state, frame capture, averaging and handshake logic.
    always_comb begin
        state_d     = state_q;
        cs_d        = cs_q;
        bit_cnt_d   = bit_cnt_q;
        rate_cnt_d  = rate_cnt_q;
        shreg_d     = shreg_q;
        b_reg_d     = b_reg_q;
        data_out_d  = data_out_q;
        frame_err_d = frame_err_q;
        tick_d      = 1'b0;
        valid_d     = valid_q;
        ovr_d       = ovr_q;
        frame_done  = 1'b0;
        publish     = 1'b0;
        new_data    = data_out_q;
`ifdef ADC_RX_AVG_EN
        acc_d       = acc_q;
        fcnt_d      = fcnt_q;
`endif

        for (int unsigned c = 0; c < N_CH; c++) begin
            frame[c] = {shreg_q[c], ADCdata[c]};
        end

        if (clear_ovr) ovr_d = 1'b0;
        if (data_ack && valid_q) valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_d = 1'b1;
                if (rx_en) begin
                    state_d    = S_CONV;
                    cs_d       = 1'b0;
                    bit_cnt_d  = '0;
                    rate_cnt_d = '0;
                end
            end
            S_CONV: begin
                rate_cnt_d = rate_cnt_q + RATE_W'(1);
                for (int unsigned c = 0; c < N_CH; c++) begin
                    shreg_d[c] = frame[c][FRAME_BITS-2:0];
                end
                if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
                    state_d    = S_DONE;
                    cs_d       = 1'b1;
                    frame_done = 1'b1;
                end else begin
                    bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                end
            end
            S_DONE: begin
                rate_cnt_d = rate_cnt_q + RATE_W'(1);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (rate_cnt_q == RATE_W'(SAMPLE_DIV - 1)) begin
                    rate_cnt_d = '0;
                    bit_cnt_d  = '0;
                    if (rx_en) begin
                        state_d = S_CONV;
                        cs_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    rate_cnt_d = rate_cnt_q + RATE_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
            end
        endcase

`ifdef ADC_RX_AVG_EN
        if (state_q == S_IDLE) begin
            acc_d  = '0;
            fcnt_d = '0;
        end
`endif

        if (frame_done) begin
            tick_d = 1'b1;
            for (int unsigned c = 0; c < N_CH; c++) begin
                b_reg_d[c*FRAME_BITS +: FRAME_BITS] = frame[c];
                frame_err_d[c] = |frame[c][FRAME_BITS-1:DATA_BITS];
            end
`ifdef ADC_RX_AVG_EN
            if (fcnt_q == 2'd3) begin
                publish = 1'b1;
                fcnt_d  = '0;
                for (int unsigned c = 0; c < N_CH; c++) begin
                    new_data[c*DATA_BITS +: DATA_BITS] =
                        DATA_BITS'((acc_q[c] + ACC_W'(frame[c][DATA_BITS-1:0])) >> 2);
                    acc_d[c] = '0;
                end
            end else begin
                fcnt_d = fcnt_q + 2'd1;
                for (int unsigned c = 0; c < N_CH; c++) begin
                    acc_d[c] = acc_q[c] + ACC_W'(frame[c][DATA_BITS-1:0]);
                end
            end
`else
            publish = 1'b1;
            for (int unsigned c = 0; c < N_CH; c++) begin
                new_data[c*DATA_BITS +: DATA_BITS] = frame[c][DATA_BITS-1:0];
            end
`endif
        end

        // A new word always leaves data_valid set; an ack in the same cycle
        // only prevents the overrun.
        if (publish) begin
            data_out_d = new_data;
            if (valid_q && !data_ack) ovr_d = 1'b1;
            valid_d = 1'b1;
        end
    end

    assign CS           = cs_q;
    assign rx_done_tick = tick_q;
    assign data_valid   = valid_q;
    assign data_out     = data_out_q;
    assign b_reg        = b_reg_q;
    assign frame_err    = frame_err_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_serial_rx_mc.sv
// Self-checking bench for adc_serial_rx_mc (N_CH=2, FRAME_BITS=16,
// DATA_BITS=12, SAMPLE_DIV=32). A behavioural ADC drives serial words; a
// frame-level reference model predicts outputs. Honours ADC_RX_AVG_EN.
module tb_adc_serial_rx_mc;

    logic        SCLK = 1'b0;
    logic        reset;
    logic        rx_en;
    logic [1:0]  ADCdata;
    logic        data_ack;
    logic        clear_ovr;
    logic        CS;
    logic        rx_done_tick;
    logic        data_valid;
    logic [23:0] data_out;
    logic [31:0] b_reg;
    logic [1:0]  frame_err;
    logic        overrun;

    adc_serial_rx_mc #(
        .N_CH      (2),
        .FRAME_BITS(16),
        .DATA_BITS (12),
        .SAMPLE_DIV(32)
    ) dut (
        .SCLK        (SCLK),
        .reset       (reset),
        .rx_en       (rx_en),
        .ADCdata     (ADCdata),
        .data_ack    (data_ack),
        .clear_ovr   (clear_ovr),
        .CS          (CS),
        .rx_done_tick(rx_done_tick),
        .data_valid  (data_valid),
        .data_out    (data_out),
        .b_reg       (b_reg),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 SCLK = ~SCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Words the ADC will send on the next CS fall
    logic [15:0] next_w0 = '0;
    logic [15:0] next_w1 = '0;

    // Reference model state (frame level)
    logic [23:0] exp_data;
    logic [31:0] exp_breg;
    logic [1:0]  exp_ferr;
    logic        exp_valid;
    logic        exp_ovr;
    int          m_frames;
    int          m_acc0;
    int          m_acc1;

    int  last_fall;
    bit  consec;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_data = '0; exp_breg = '0; exp_ferr = '0;
        exp_valid = 1'b0; exp_ovr = 1'b0;
        m_frames = 0; m_acc0 = 0; m_acc1 = 0;
    endtask

    // mode: 0 no ack, 1 ack on completion edge, 2 ack after completion,
    // 3 no ack but clear_ovr on completion edge
    task automatic model_complete(input logic [15:0] w0, input logic [15:0] w1, input int mode);
        bit pub;
        exp_breg = {w1, w0};
        exp_ferr = {(w1[15:12] != 4'h0), (w0[15:12] != 4'h0)};
`ifdef ADC_RX_AVG_EN
        m_acc0 += int'(w0[11:0]);
        m_acc1 += int'(w1[11:0]);
        m_frames++;
        pub = (m_frames == 4);
        if (pub) begin
            exp_data = {12'(m_acc1 / 4), 12'(m_acc0 / 4)};
            m_frames = 0; m_acc0 = 0; m_acc1 = 0;
        end
`else
        pub = 1'b1;
        exp_data = {w1[11:0], w0[11:0]};
`endif
        if (mode == 3) exp_ovr = 1'b0;
        if (pub) begin
            if (exp_valid && mode != 1) exp_ovr = 1'b1;
            exp_valid = 1'b1;
        end else if (mode == 1) begin
            exp_valid = 1'b0;
        end
    endtask

    // Behavioural ADC: presents the next bit after each falling edge while CS is low
    initial begin
        logic [15:0] cur0, cur1;
        int idx;
        idx = 0; cur0 = '0; cur1 = '0;
        ADCdata = '0;
        forever begin
            @(negedge SCLK);
            if (CS === 1'b0 && idx < 16) begin
                if (idx == 0) begin
                    cur0 = next_w0;
                    cur1 = next_w1;
                end
                ADCdata = {cur1[15 - idx], cur0[15 - idx]};
                idx++;
            end else begin
                idx = 0;
                ADCdata = 2'($urandom);
            end
        end
    end

    initial forever begin
        @(posedge SCLK);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_frame(input logic [15:0] w0, input logic [15:0] w1,
                            input int mode, input int drop);
        int j;
        bit seen;
        next_w0 = w0;
        next_w1 = w1;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge SCLK);
            if (CS === 1'b0) seen = 1'b1;
        end
        chk("cs_fall", 64'(seen), 64'd1);
        if (!seen) return;
        if (consec) chk("cs_period", 64'(cyc - last_fall), 64'd32);
        last_fall = cyc;
        consec = 1'b1;
        j = 0;
        while (j < 40 && rx_done_tick !== 1'b1) begin
            @(negedge SCLK);
            j++;
            if (j == 15 && mode == 1) data_ack = 1'b1;
            if (j == 15 && mode == 3) clear_ovr = 1'b1;
            if (j == drop) rx_en = 1'b0;
        end
        chk("latency", 64'(j), 64'd16);
        data_ack = 1'b0;
        clear_ovr = 1'b0;
        model_complete(w0, w1, mode);
        chk("data_out", 64'(data_out), 64'(exp_data));
        chk("frame_err", 64'(frame_err), 64'(exp_ferr));
        chk("b_reg", 64'(b_reg), 64'(exp_breg));
        chk("valid_done", 64'(data_valid), 64'(exp_valid));
        chk("overrun_done", 64'(overrun), 64'(exp_ovr));
        if (mode == 2) data_ack = 1'b1;
        @(negedge SCLK);
        data_ack = 1'b0;
        if (mode == 2) exp_valid = 1'b0;
        chk("tick_one_cycle", 64'(rx_done_tick), 64'd0);
        chk("cs_high_after", 64'(CS), 64'd1);
        chk("valid_after", 64'(data_valid), 64'(exp_valid));
    endtask

    task automatic pulse_clear();
        clear_ovr = 1'b1;
        @(negedge SCLK);
        clear_ovr = 1'b0;
        exp_ovr = 1'b0;
        chk("clear_ovr", 64'(overrun), 64'(exp_ovr));
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom_range(0, 4095));
        if ($urandom_range(0, 3) == 0) w[15:12] = 4'($urandom);
        return w;
    endfunction

    initial begin
        int ticks, cs_low;
        reset = 1'b0; rx_en = 1'b0; data_ack = 1'b0; clear_ovr = 1'b0;
        consec = 1'b0; last_fall = 0;
        model_reset();

        // Reset state
        repeat (3) @(negedge SCLK);
        chk("rst_cs", 64'(CS), 64'd1);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_valid", 64'(data_valid), 64'd0);
        chk("rst_tick", 64'(rx_done_tick), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        chk("rst_breg", 64'(b_reg), 64'd0);
        reset = 1'b1;
        repeat (4) @(negedge SCLK);
        chk("idle_cs", 64'(CS), 64'd1);

        // Directed frames, then overrun handling
        rx_en = 1'b1;
        do_frame(16'h0ABC, 16'h0123, 2, -1);
        do_frame(16'h8ABC, rand_word() & 16'h0FFF, 2, -1);
        do_frame(rand_word(), rand_word(), 0, -1);
        do_frame(rand_word(), rand_word(), 0, -1);
        pulse_clear();
        do_frame(rand_word(), rand_word(), 1, -1);
        do_frame(rand_word(), rand_word(), 3, -1);
        pulse_clear();
        do_frame(rand_word(), rand_word(), 2, -1);

        // Randomised frames with random handshake behaviour
        for (int n = 0; n < 10; n++) begin
            do_frame(rand_word(), rand_word(), int'($urandom_range(0, 3)), -1);
            if ($urandom_range(0, 2) == 0) pulse_clear();
        end

        // rx_en dropped mid-frame: frame completes, then the receiver idles
        do_frame(rand_word(), rand_word(), 2, 7);
        ticks = 0; cs_low = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge SCLK);
            if (rx_done_tick === 1'b1) ticks++;
            if (CS !== 1'b1) cs_low++;
        end
        chk("idle_no_tick", 64'(ticks), 64'd0);
        chk("idle_cs_high", 64'(cs_low), 64'd0);
        m_frames = 0; m_acc0 = 0; m_acc1 = 0;
        consec = 1'b0;

        // Reset in the middle of a frame
        next_w0 = rand_word(); next_w1 = rand_word();
        rx_en = 1'b1;
        for (int i = 0; i < 10 && CS !== 1'b0; i++) @(negedge SCLK);
        chk("cs_fall_before_rst", 64'(CS), 64'd0);
        repeat (5) @(negedge SCLK);
        reset = 1'b0;
        #1;
        chk("midrst_cs", 64'(CS), 64'd1);
        chk("midrst_data_out", 64'(data_out), 64'd0);
        chk("midrst_valid", 64'(data_valid), 64'd0);
        chk("midrst_ovr", 64'(overrun), 64'd0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge SCLK);
            if (rx_done_tick === 1'b1) ticks++;
        end
        chk("midrst_no_tick", 64'(ticks), 64'd0);
        model_reset();
        reset = 1'b1;

        // Four frames without ack (boxcar group when averaging is enabled)
        do_frame(16'h0100, rand_word(), 0, -1);
        do_frame(16'h0102, rand_word(), 0, -1);
        do_frame(16'h0104, rand_word(), 0, -1);
        do_frame(16'h0106, rand_word(), 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
